// File: rtl/lc3_ctrl_pkg.sv
// Shared types and opcode classifiers for the LC-3 pipeline controller.
package lc3_ctrl_pkg;

  typedef enum logic [3:0] {
    OP_BR  = 4'b0000,
    OP_ADD = 4'b0001,
    OP_LD  = 4'b0010,
    OP_ST  = 4'b0011,
    OP_AND = 4'b0101,
    OP_LDR = 4'b0110,
    OP_STR = 4'b0111,
    OP_NOT = 4'b1001,
    OP_LDI = 4'b1010,
    OP_STI = 4'b1011,
    OP_JMP = 4'b1100,
    OP_LEA = 4'b1110
  } opcode_t;

  typedef enum logic [1:0] {
    MS_READ  = 2'd0,
    MS_IND   = 2'd1,
    MS_WRITE = 2'd2,
    MS_IDLE  = 2'd3
  } mem_state_t;

  localparam int unsigned BR_BUBBLE_DEFAULT = 3;

  function automatic logic is_mem_op(input logic [3:0] op);
    case (op)
      OP_LD, OP_LDR, OP_LDI, OP_ST, OP_STR, OP_STI: is_mem_op = 1'b1;
      default:                                      is_mem_op = 1'b0;
    endcase
  endfunction

  function automatic logic is_ctrl_op(input logic [3:0] op);
    case (op)
      OP_BR, OP_JMP: is_ctrl_op = 1'b1;
      default:       is_ctrl_op = 1'b0;
    endcase
  endfunction

  function automatic logic is_alu_op(input logic [3:0] op);
    case (op)
      OP_ADD, OP_AND, OP_NOT: is_alu_op = 1'b1;
      default:                is_alu_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lc3_mem_fsm.sv
// Data-memory access sequencer: READ / IND / WRITE / IDLE, plus the
// writeback strobe raised in the cycle a READ completes.
module lc3_mem_fsm
  import lc3_ctrl_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic [3:0] op_i,
  input  logic       complete_i,
  output mem_state_t state_o,
  output logic       rd_done_o
);

  mem_state_t state_q;
  logic       store_q;

  // Entry only from IDLE; every exit waits for at least one cycle in-state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= MS_IDLE;
      store_q <= 1'b0;
    end else begin
      case (state_q)
        MS_IDLE: begin
          if (start_i) begin
            case (op_i)
              OP_LD, OP_LDR: state_q <= MS_READ;
              OP_ST, OP_STR: state_q <= MS_WRITE;
              OP_LDI: begin
                state_q <= MS_IND;
                store_q <= 1'b0;
              end
              OP_STI: begin
                state_q <= MS_IND;
                store_q <= 1'b1;
              end
              default: state_q <= MS_IDLE;
            endcase
          end
        end
        MS_IND: begin
          if (complete_i) begin
            state_q <= store_q ? MS_WRITE : MS_READ;
          end
        end
        MS_READ, MS_WRITE: begin
          if (complete_i) begin
            state_q <= MS_IDLE;
          end
        end
        default: state_q <= MS_IDLE;
      endcase
    end
  end

  assign state_o   = state_q;
  assign rd_done_o = (state_q == MS_READ) && complete_i;

endmodule

// File: rtl/lc3_pipe_controller.sv
// LC-3 pipeline sequencer: startup fill, branch bubble and stage enables.
// Optional execute-operand forwarding is built when LC3_CTRL_BYPASS_EN is defined.
module lc3_pipe_controller
  import lc3_ctrl_pkg::*;
#(
  parameter int unsigned BR_BUBBLE   = BR_BUBBLE_DEFAULT,
  parameter int unsigned FILL_STAGES = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] IR,
  input  logic [15:0] IR_Exec,
  input  logic [2:0]  NZP,
  input  logic        complete_instr,
  input  logic        complete_data,
  output logic        enable_updatePC,
  output logic        enable_fetch,
  output logic        enable_decode,
  output logic        enable_execute,
  output logic        enable_writeback,
  output logic        br_taken,
  output logic [1:0]  mem_state,
  output logic        bypass_alu_1,
  output logic        bypass_alu_2
);

  localparam logic [2:0] BUBBLE_LOAD = 3'(BR_BUBBLE);
  localparam logic [2:0] FILL_MAX    = 3'(FILL_STAGES);

  logic [2:0] fill_q, fill_d;
  logic [2:0] bubble_q, bubble_d;
  logic [3:0] op_dec_s, op_exe_s;
  mem_state_t ms_s;
  logic       rd_done_s, stall_s, mem_start_s;
  logic       filled_f_s, filled_d_s, filled_e_s, filled_w_s;
  logic       unused_bits_s;

  assign op_dec_s      = IR[15:12];
  assign op_exe_s      = IR_Exec[15:12];
  assign unused_bits_s = ^{IR[11:0], IR_Exec[8:0]};

  assign stall_s    = (ms_s != MS_IDLE);
  assign filled_f_s = (fill_q >= 3'd1);
  assign filled_d_s = (fill_q >= 3'd2);
  assign filled_e_s = (fill_q >= 3'd3);
  assign filled_w_s = (fill_q >= 3'd4);

  // Stage enables and branch resolution from registered state.
  always_comb begin
    enable_fetch     = filled_f_s && !stall_s && (bubble_q == 3'd0) && complete_instr;
    enable_updatePC  = enable_fetch;
    enable_decode    = filled_d_s && !stall_s && (bubble_q == 3'd0);
    enable_execute   = filled_e_s && !stall_s;
    enable_writeback = (filled_w_s && !stall_s) || rd_done_s;
    br_taken         = enable_execute &&
                       ((op_exe_s == OP_JMP) ||
                        ((op_exe_s == OP_BR) && (|(IR_Exec[11:9] & NZP))));
    mem_start_s      = enable_execute && is_mem_op(op_exe_s);
  end

  // Next-state for the fill ramp and the post-branch bubble countdown.
  always_comb begin
    if (fill_q < FILL_MAX) begin
      fill_d = fill_q + 3'd1;
    end else begin
      fill_d = fill_q;
    end
    if (enable_decode && is_ctrl_op(op_dec_s)) begin
      bubble_d = BUBBLE_LOAD;
    end else if (!stall_s && (bubble_q != 3'd0)) begin
      bubble_d = bubble_q - 3'd1;
    end else begin
      bubble_d = bubble_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fill_q   <= 3'd0;
      bubble_q <= 3'd0;
    end else begin
      fill_q   <= fill_d;
      bubble_q <= bubble_d;
    end
  end

  lc3_mem_fsm u_mem_fsm (
    .clk_i      (clock),
    .rst_ni     (reset),
    .start_i    (mem_start_s),
    .op_i       (op_exe_s),
    .complete_i (complete_data),
    .state_o    (ms_s),
    .rd_done_o  (rd_done_s)
  );

  assign mem_state = ms_s;

`ifdef LC3_CTRL_BYPASS_EN
  // Forward the ALU result when decode reads the register execute is writing.
  always_comb begin
    bypass_alu_1 = enable_execute && is_alu_op(op_exe_s) && is_alu_op(op_dec_s) &&
                   (IR[8:6] == IR_Exec[11:9]);
    bypass_alu_2 = enable_execute && is_alu_op(op_exe_s) && is_alu_op(op_dec_s) &&
                   !IR[5] && (IR[2:0] == IR_Exec[11:9]);
  end
`else
  assign bypass_alu_1 = 1'b0;
  assign bypass_alu_2 = 1'b0;
`endif

endmodule

// File: tb/tb_lc3_pipe_controller.sv
// Directed per-cycle vector table for lc3_pipe_controller plus a reset-mid-READ sequence.
module tb_lc3_pipe_controller;

  localparam logic [15:0] N  = 16'hF000;
`ifdef LC3_CTRL_BYPASS_EN
  localparam logic        BY = 1'b1;
`else
  localparam logic        BY = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] IR, IR_Exec;
  logic [2:0]  NZP;
  logic        complete_instr, complete_data;
  logic        enable_updatePC, enable_fetch, enable_decode, enable_execute, enable_writeback;
  logic        br_taken, bypass_alu_1, bypass_alu_2;
  logic [1:0]  mem_state;
  logic [9:0]  obs;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        rst;
    logic [15:0] ir;
    logic [15:0] irx;
    logic [2:0]  nzp;
    logic        ci;
    logic        cd;
    logic [9:0]  exp;
  } vec_t;

  vec_t tbl[$];

  lc3_pipe_controller dut (
    .clock            (clock),
    .reset            (reset),
    .IR               (IR),
    .IR_Exec          (IR_Exec),
    .NZP              (NZP),
    .complete_instr   (complete_instr),
    .complete_data    (complete_data),
    .enable_updatePC  (enable_updatePC),
    .enable_fetch     (enable_fetch),
    .enable_decode    (enable_decode),
    .enable_execute   (enable_execute),
    .enable_writeback (enable_writeback),
    .br_taken         (br_taken),
    .mem_state        (mem_state),
    .bypass_alu_1     (bypass_alu_1),
    .bypass_alu_2     (bypass_alu_2)
  );

  always #5 clock = ~clock;

  assign obs = {enable_updatePC, enable_fetch, enable_decode, enable_execute,
                enable_writeback, br_taken, mem_state, bypass_alu_1, bypass_alu_2};

  // en = {updatePC, fetch, decode, execute, writeback}
  function automatic vec_t mk(input logic rst, input logic [15:0] ir, input logic [15:0] irx,
                              input logic [2:0] nzp, input logic ci, input logic cd,
                              input logic [4:0] en, input logic br, input logic [1:0] ms,
                              input logic [1:0] byp);
    vec_t v;
    v.rst = rst; v.ir = ir; v.irx = irx; v.nzp = nzp; v.ci = ci; v.cd = cd;
    v.exp = {en, br, ms, byp};
    return v;
  endfunction

  task automatic check(input string nm, input int idx, input logic [9:0] act, input logic [9:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got {pc,f,d,e,wb,br,ms,b1,b2}=%b expected %b", nm, idx, act, exp);
    end
  endtask

  initial begin
    reset = 1'b0; IR = N; IR_Exec = N; NZP = 3'b000;
    complete_instr = 1'b1; complete_data = 1'b0;

    // reset and fill ramp
    tbl.push_back(mk(1'b0, N, N, 3'b000, 1'b1, 1'b0, 5'b00000, 1'b0, 2'd3, 2'b00));
    tbl.push_back(mk(1'b1, N, N, 3'b000, 1'b1, 1'b0, 5'b00000, 1'b0, 2'd3, 2'b00));
    tbl.push_back(mk(1'b1, N, N, 3'b000, 1'b1, 1'b0, 5'b11000, 1'b0, 2'd3, 2'b00));
    tbl.push_back(mk(1'b1, N, N, 3'b000, 1'b1, 1'b0, 5'b11100, 1'b0, 2'd3, 2'b00));
    tbl.push_back(mk(1'b1, N, N, 3'b000, 1'b1, 1'b0, 5'b11110, 1'b0, 2'd3, 2'b00));
    tbl.push_back(mk(1'b1, N, N, 3'b000, 1'b1, 1'b0, 5'b11111, 1'b0, 2'd3, 2'b00));
    tbl.push_back(mk(1'b1, N, N, 3'b000, 1'b0, 1'b0, 5'b00111, 1'b0, 2'd3, 2'b00));
    // LDR, complete_data in entry cycle ignored, done two cycles later
    tbl.push_back(mk(1'b1, N, 16'h6000, 3'b000, 1'b1, 1'b1, 5'b11111, 1'b0, 2'd3, 2'b00));
    tbl.push_back(mk(1'b1, N, 16'h6000, 3'b000, 1'b1, 1'b0, 5'b00000, 1'b0, 2'd0, 2'b00));
    tbl.push_back(mk(1'b1, N, 16'h6000, 3'b000, 1'b1, 1'b1, 5'b00001, 1'b0, 2'd0, 2'b00));
    tbl.push_back(mk(1'b1, N, N, 3'b000, 1'b1, 1'b0, 5'b11111, 1'b0, 2'd3, 2'b00));
    // STI: IND -> WRITE -> IDLE, no writeback
    tbl.push_back(mk(1'b1, N, 16'hB000, 3'b000, 1'b1, 1'b0, 5'b11111, 1'b0, 2'd3, 2'b00));
    tbl.push_back(mk(1'b1, N, 16'hB000, 3'b000, 1'b1, 1'b1, 5'b00000, 1'b0, 2'd1, 2'b00));
    tbl.push_back(mk(1'b1, N, 16'hB000, 3'b000, 1'b1, 1'b0, 5'b00000, 1'b0, 2'd2, 2'b00));
    tbl.push_back(mk(1'b1, N, 16'hB000, 3'b000, 1'b1, 1'b1, 5'b00000, 1'b0, 2'd2, 2'b00));
    tbl.push_back(mk(1'b1, N, N, 3'b000, 1'b1, 1'b0, 5'b11111, 1'b0, 2'd3, 2'b00));
    // LDI: IND -> READ -> IDLE with writeback
    tbl.push_back(mk(1'b1, N, 16'hA000, 3'b000, 1'b1, 1'b0, 5'b11111, 1'b0, 2'd3, 2'b00));
    tbl.push_back(mk(1'b1, N, 16'hA000, 3'b000, 1'b1, 1'b1, 5'b00000, 1'b0, 2'd1, 2'b00));
    tbl.push_back(mk(1'b1, N, 16'hA000, 3'b000, 1'b1, 1'b1, 5'b00001, 1'b0, 2'd0, 2'b00));
    tbl.push_back(mk(1'b1, N, N, 3'b000, 1'b1, 1'b0, 5'b11111, 1'b0, 2'd3, 2'b00));
    // BR n taken (NZP=100), three bubble cycles
    tbl.push_back(mk(1'b1, 16'h0800, N, 3'b100, 1'b1, 1'b0, 5'b11111, 1'b0, 2'd3, 2'b00));
    tbl.push_back(mk(1'b1, N, 16'h0800, 3'b100, 1'b1, 1'b0, 5'b00011, 1'b1, 2'd3, 2'b00));
    tbl.push_back(mk(1'b1, N, N, 3'b100, 1'b1, 1'b0, 5'b00011, 1'b0, 2'd3, 2'b00));
    tbl.push_back(mk(1'b1, N, N, 3'b100, 1'b1, 1'b0, 5'b00011, 1'b0, 2'd3, 2'b00));
    tbl.push_back(mk(1'b1, N, N, 3'b100, 1'b1, 1'b0, 5'b11111, 1'b0, 2'd3, 2'b00));
    // BR n not taken (NZP=010)
    tbl.push_back(mk(1'b1, 16'h0800, N, 3'b010, 1'b1, 1'b0, 5'b11111, 1'b0, 2'd3, 2'b00));
    tbl.push_back(mk(1'b1, N, 16'h0800, 3'b010, 1'b1, 1'b0, 5'b00011, 1'b0, 2'd3, 2'b00));
    tbl.push_back(mk(1'b1, N, N, 3'b010, 1'b1, 1'b0, 5'b00011, 1'b0, 2'd3, 2'b00));
    tbl.push_back(mk(1'b1, N, N, 3'b010, 1'b1, 1'b0, 5'b00011, 1'b0, 2'd3, 2'b00));
    tbl.push_back(mk(1'b1, N, N, 3'b010, 1'b1, 1'b0, 5'b11111, 1'b0, 2'd3, 2'b00));
    // JMP always redirects
    tbl.push_back(mk(1'b1, 16'hC1C0, N, 3'b000, 1'b1, 1'b0, 5'b11111, 1'b0, 2'd3, 2'b00));
    tbl.push_back(mk(1'b1, N, 16'hC1C0, 3'b000, 1'b1, 1'b0, 5'b00011, 1'b1, 2'd3, 2'b00));
    tbl.push_back(mk(1'b1, N, N, 3'b000, 1'b1, 1'b0, 5'b00011, 1'b0, 2'd3, 2'b00));
    tbl.push_back(mk(1'b1, N, N, 3'b000, 1'b1, 1'b0, 5'b00011, 1'b0, 2'd3, 2'b00));
    tbl.push_back(mk(1'b1, N, N, 3'b000, 1'b1, 1'b0, 5'b11111, 1'b0, 2'd3, 2'b00));
    // LD in execute with BR in decode: bubble loads, then frozen across the stall
    tbl.push_back(mk(1'b1, 16'h0E00, 16'h2000, 3'b010, 1'b1, 1'b0, 5'b11111, 1'b0, 2'd3, 2'b00));
    tbl.push_back(mk(1'b1, N, 16'h2000, 3'b010, 1'b1, 1'b0, 5'b00000, 1'b0, 2'd0, 2'b00));
    tbl.push_back(mk(1'b1, N, 16'h2000, 3'b010, 1'b1, 1'b1, 5'b00001, 1'b0, 2'd0, 2'b00));
    tbl.push_back(mk(1'b1, N, N, 3'b010, 1'b1, 1'b0, 5'b00011, 1'b0, 2'd3, 2'b00));
    tbl.push_back(mk(1'b1, N, N, 3'b010, 1'b1, 1'b0, 5'b00011, 1'b0, 2'd3, 2'b00));
    tbl.push_back(mk(1'b1, N, N, 3'b010, 1'b1, 1'b0, 5'b00011, 1'b0, 2'd3, 2'b00));
    tbl.push_back(mk(1'b1, N, N, 3'b010, 1'b1, 1'b0, 5'b11111, 1'b0, 2'd3, 2'b00));
    // bypass: ADD R3 in execute, ADD R1,R3,R3 / ADD R1,R3,#3 / LEA in execute
    tbl.push_back(mk(1'b1, 16'h12C3, 16'h1640, 3'b000, 1'b1, 1'b0, 5'b11111, 1'b0, 2'd3, {BY, BY}));
    tbl.push_back(mk(1'b1, 16'h12E3, 16'h1640, 3'b000, 1'b1, 1'b0, 5'b11111, 1'b0, 2'd3, {BY, 1'b0}));
    tbl.push_back(mk(1'b1, 16'h12C3, 16'hE600, 3'b000, 1'b1, 1'b0, 5'b11111, 1'b0, 2'd3, 2'b00));

    foreach (tbl[i]) begin
      @(negedge clock);
      reset = tbl[i].rst; IR = tbl[i].ir; IR_Exec = tbl[i].irx; NZP = tbl[i].nzp;
      complete_instr = tbl[i].ci; complete_data = tbl[i].cd;
      #4;
      check("vec", i, obs, tbl[i].exp);
    end

    // reset asserted mid-READ: immediate effect, then the fill restarts
    @(negedge clock);
    reset = 1'b1; IR = N; IR_Exec = 16'h6000; NZP = 3'b000; complete_instr = 1'b1; complete_data = 1'b0;
    #4;
    check("rst_entry", 0, obs, {5'b11111, 1'b0, 2'd3, 2'b00});
    @(negedge clock);
    #1;
    check("rst_in_read", 0, obs, {5'b00000, 1'b0, 2'd0, 2'b00});
    reset = 1'b0;
    #1;
    check("rst_immediate", 0, obs, {5'b00000, 1'b0, 2'd3, 2'b00});
    @(negedge clock);
    reset = 1'b1; IR_Exec = N; complete_data = 1'b1;
    #4;
    check("rst_release", 0, obs, {5'b00000, 1'b0, 2'd3, 2'b00});
    for (int k = 1; k <= 4; k++) begin
      logic [4:0] en_exp;
      en_exp = 5'b11111 << (5 - (k + 1));
      @(negedge clock);
      #4;
      check("refill", k, obs, {en_exp, 1'b0, 2'd3, 2'b00});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
